countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Down-counting HH:MM:SS timer; the count-down counterpart of the up-counting board timer.
//  The user presets a time with two buttons, then starts, pauses or resumes the count.
//  At 00:00:00 the timer raises an alarm, then returns to the set mode.
//  Output drives the same 6-digit multiplexed 7-segment display as the up-counter.
//  Sits downstream of the 1 kHz divider (kclk) on the lab board.
// PARAMETERS
//  TICK_DIV      1000  kclk cycles per 1 s tick (speed=0)
//  DEB_LEN       7     consecutive high kclk samples required to accept a button press
//  ALARM_CYCLES  3000  kclk cycles alarm stays asserted (3 s)
// PORTS
//  kclk       in   1  1 kHz system clock; all state on posedge kclk
//  rst        in   1  reset, asynchronous, active-high
//  btn_start  in   1  raw button: start/pause/resume/acknowledge
//  btn_sel    in   1  raw button: cycle selected field in SET (hours->min->sec->hours)
//  btn_inc    in   1  raw button: increment selected field in SET
//  speed      in   1  1: one tick per kclk cycle (fast/sim); 0: one tick per TICK_DIV cycles
//  seg        out  7  abcdefg, active-high, for digit addressed by de
//  de         out  3  digit select 0..5 = h1,h0,m1,m0,s1,s0
//  alarm      out  1  high while in ALARM
//  running    out  1  high while in RUN
//  sel_field  out  2  0=hours, 1=minutes, 2=seconds (valid in SET)
// BEHAVIOUR
//  Reset: state=SET; all digits 0; sel_field=0; prescaler 0; de=0; alarm=0; running=0;
//   debouncer shift registers cleared.
//  Buttons: shift in each kclk; press level = all DEB_LEN samples high.
//   Rising edge of the level gives a 1-cycle pulse (start_p, sel_p, inc_p).
//  States:
//   SET:   sel_p advances sel_field 0->1->2->0.
//          inc_p increments selected field (BCD): hours 00..11, wraps 11->00;
//          min/sec 00..59, wraps 59->00. No carry into other fields.
//          start_p with time != 00:00:00 -> RUN, prescaler cleared.
//          start_p with time == 0 is ignored.
//   RUN:   on tick, decrement with BCD borrow chain s0->s1->m0->m1->h0->h1.
//          s0 0->9 borrows; s1 0->5 borrows; m0/m1 likewise; h0 0->9 borrows from h1.
//          Tick with time == 00:00:00 -> ALARM; digits stay 0. A zero value therefore
//          displays for one full tick before the alarm.
//          start_p -> PAUSE; the tick coincident with start_p is discarded.
//   PAUSE: digits frozen; prescaler held. start_p -> RUN (prescaler resumes, not cleared).
//          sel_p/inc_p ignored.
//   ALARM: alarm=1; internal counter runs ALARM_CYCLES kclk cycles, then -> SET.
//          start_p -> SET immediately (early acknowledge). Digits remain 0.
//  Simultaneous pulses: start_p has priority over sel_p over inc_p. Only one takes effect
//   per cycle.
//  Prescaler: counts 0..TICK_DIV-1 in RUN only; tick = 1-cycle pulse on wrap.
//   speed=1 forces tick every RUN cycle. Changing speed mid-run is allowed and needs no
//   resynchronisation.
//  Display: de increments every kclk, wraps 5->0, free-running in all states.
//   seg is combinational from the digit selected by de:
//     0=1111110  1=0110000  2=1101101  3=1111001  4=0110011
//     5=1011011  6=1011111  7=1110000  8=1111111  9=1111011
//     other=0011111
//  Widths: digits 4-bit BCD; prescaler $clog2(TICK_DIV); alarm counter $clog2(ALARM_CYCLES).
//  Reset asserted mid-operation (any state) aborts immediately to the reset values.
// STRUCTURE
//  Shared package: state encoding (SET/RUN/PAUSE/ALARM), 7-seg digit constants,
//   field index constants.
//  Sub-module: btn_debounce_edge (DEB_LEN param; kclk, rst, raw -> pulse).
//   Instantiated 3 times.
//  Remainder (FSM, prescaler, BCD down-counter, display mux) lives in countdown_timer.
// TESTING
//  1 Reset: rst pulse mid-RUN at 00:05:00 -> digits 0, SET, alarm=0, de=0, same cycle.
//  2 Set: sel x2 (seconds), inc x61 -> 00:00:01. sel x1 (hours), inc x13 -> 01:00:01.
//  3 Borrow: preset 01:00:00, speed=1, start -> next ticks 00:59:59, 00:59:58.
//  4 Expiry: preset 00:00:02, speed=1, start -> 01, 00, then ALARM. alarm=1 for exactly
//    ALARM_CYCLES cycles, then SET with 00:00:00.
//  5 Pause: RUN at 00:00:30, press start -> frozen for 5000 cycles. Start again -> resumes
//    from 00:00:30. Start at 00:00:00 in SET -> stays SET.
//  6 Debounce/priority: 6-cycle glitch on btn_inc -> no change. Start and inc pressed in the
//    same cycle -> only state change. de sequence 0..5,0 and seg=1111110 for digit 0.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the HH:MM:SS countdown timer.
// State encoding, field indices, BCD time arithmetic, 7-seg decode.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_SET,
        ST_RUN,
        ST_PAUSE,
        ST_ALARM
    } state_t;

    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    localparam logic [1:0] FLD_HR  = 2'd0;
    localparam logic [1:0] FLD_MIN = 2'd1;
    localparam logic [1:0] FLD_SEC = 2'd2;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_BAD = 7'b0011111;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BAD;
        endcase
        return s;
    endfunction

    // Two-digit BCD increment wrapping max -> 00, no carry out.
    function automatic logic [7:0] inc2(
        input logic [3:0] tens,
        input logic [3:0] ones,
        input logic [3:0] max_t,
        input logic [3:0] max_o
    );
        logic [7:0] r;
        if (tens == max_t && ones == max_o)
            r = 8'h00;
        else if (ones == 4'd9)
            r = {tens + 4'd1, 4'd0};
        else
            r = {tens, ones + 4'd1};
        return r;
    endfunction

    function automatic bcd_time_t bcd_inc(
        input bcd_time_t  t,
        input logic [1:0] fld
    );
        bcd_time_t r;
        r = t;
        case (fld)
            FLD_HR:  {r.h1, r.h0} = inc2(t.h1, t.h0, 4'd1, 4'd1);
            FLD_MIN: {r.m1, r.m0} = inc2(t.m1, t.m0, 4'd5, 4'd9);
            FLD_SEC: {r.s1, r.s0} = inc2(t.s1, t.s0, 4'd5, 4'd9);
            default: r = t;
        endcase
        return r;
    endfunction

    // Borrow chain s0->s1->m0->m1->h0->h1; caller guarantees t != 0.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.s0 != 4'd0) begin
            r.s0 = t.s0 - 4'd1;
        end else begin
            r.s0 = 4'd9;
            if (t.s1 != 4'd0) begin
                r.s1 = t.s1 - 4'd1;
            end else begin
                r.s1 = 4'd5;
                if (t.m0 != 4'd0) begin
                    r.m0 = t.m0 - 4'd1;
                end else begin
                    r.m0 = 4'd9;
                    if (t.m1 != 4'd0) begin
                        r.m1 = t.m1 - 4'd1;
                    end else begin
                        r.m1 = 4'd5;
                        if (t.h0 != 4'd0) begin
                            r.h0 = t.h0 - 4'd1;
                        end else begin
                            r.h0 = 4'd9;
                            r.h1 = t.h1 - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_debounce.sv
// Button debouncer: DEB_LEN high samples form a press level,
// whose rising edge yields a single-cycle pulse.
module btn_debounce_edge #(
    parameter int DEB_LEN = 7
) (
    input  logic kclk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    logic [DEB_LEN-1:0] sr;
    logic               level;
    logic               level_q;

    assign level = &sr;
    assign pulse = level & ~level_q;

    // Sample history and delayed level for edge detection.
    always_ff @(posedge kclk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            level_q <= 1'b0;
        end else begin
            sr      <= {sr[DEB_LEN-2:0], raw};
            level_q <= level;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS down-counter with preset, pause and alarm,
// driving a 6-digit multiplexed 7-segment display.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV     = 1000,
    parameter int DEB_LEN      = 7,
    parameter int ALARM_CYCLES = 3000
) (
    input  logic       kclk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       speed,
    output logic [6:0] seg,
    output logic [2:0] de,
    output logic       alarm,
    output logic       running,
    output logic [1:0] sel_field
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALM_MAX = AW'(ALARM_CYCLES - 1);

    state_t        state_q, state_d;
    bcd_time_t     tm_q, tm_d;
    logic [1:0]    sel_q, sel_d;
    logic [PW-1:0] pre_q;
    logic [AW-1:0] alm_q;
    logic          start_p, sel_p, inc_p;
    logic          tick;
    logic          tm_zero;
    logic [3:0]    dig;

    btn_debounce_edge #(.DEB_LEN(DEB_LEN)) u_deb_start (
        .kclk  (kclk),
        .rst   (rst),
        .raw   (btn_start),
        .pulse (start_p)
    );

    btn_debounce_edge #(.DEB_LEN(DEB_LEN)) u_deb_sel (
        .kclk  (kclk),
        .rst   (rst),
        .raw   (btn_sel),
        .pulse (sel_p)
    );

    btn_debounce_edge #(.DEB_LEN(DEB_LEN)) u_deb_inc (
        .kclk  (kclk),
        .rst   (rst),
        .raw   (btn_inc),
        .pulse (inc_p)
    );

    assign tm_zero   = (tm_q == '0);
    assign tick      = (state_q == ST_RUN) &&
                       (speed || pre_q == PRE_MAX);
    assign alarm     = (state_q == ST_ALARM);
    assign running   = (state_q == ST_RUN);
    assign sel_field = sel_q;

    // State, time digits and field selector registers.
    always_ff @(posedge kclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SET;
            tm_q    <= '0;
            sel_q   <= FLD_HR;
        end else begin
            state_q <= state_d;
            tm_q    <= tm_d;
            sel_q   <= sel_d;
        end
    end

    // Next state; start beats sel beats inc, one action per cycle.
    always_comb begin
        state_d = state_q;
        tm_d    = tm_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_SET: begin
                if (start_p) begin
                    if (!tm_zero)
                        state_d = ST_RUN;
                end else if (sel_p) begin
                    sel_d = (sel_q == FLD_SEC) ? FLD_HR
                                               : sel_q + 2'd1;
                end else if (inc_p) begin
                    tm_d = bcd_inc(tm_q, sel_q);
                end
            end
            ST_RUN: begin
                if (start_p) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (tm_zero)
                        state_d = ST_ALARM;
                    else
                        tm_d = bcd_dec(tm_q);
                end
            end
            ST_PAUSE: begin
                if (start_p)
                    state_d = ST_RUN;
            end
            ST_ALARM: begin
                if (start_p || alm_q == ALM_MAX)
                    state_d = ST_SET;
            end
            default: state_d = ST_SET;
        endcase
    end

    // Prescaler: cleared in SET, counts in RUN, held otherwise.
    always_ff @(posedge kclk or posedge rst) begin
        if (rst)
            pre_q <= '0;
        else if (state_q == ST_SET)
            pre_q <= '0;
        else if (state_q == ST_RUN)
            pre_q <= (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    end

    // Alarm duration counter, restarted on every ALARM entry.
    always_ff @(posedge kclk or posedge rst) begin
        if (rst)
            alm_q <= '0;
        else if (state_q == ST_ALARM)
            alm_q <= alm_q + 1'b1;
        else
            alm_q <= '0;
    end

    // Free-running digit scan 0..5.
    always_ff @(posedge kclk or posedge rst) begin
        if (rst)
            de <= 3'd0;
        else
            de <= (de == 3'd5) ? 3'd0 : de + 3'd1;
    end

    // Display mux: pick the scanned digit and decode it.
    always_comb begin
        dig = 4'hF;
        unique case (de)
            3'd0:    dig = tm_q.h1;
            3'd1:    dig = tm_q.h0;
            3'd2:    dig = tm_q.m1;
            3'd3:    dig = tm_q.m0;
            3'd4:    dig = tm_q.s1;
            3'd5:    dig = tm_q.s0;
            default: dig = 4'hF;
        endcase
        seg = seg_of(dig);
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: preset, borrow, expiry,
// pause, debounce, priority, reset and display scan.
module tb_countdown_timer;

    logic       kclk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_sel = 1'b0;
    logic       btn_inc = 1'b0;
    logic       speed = 1'b0;
    logic [6:0] seg;
    logic [2:0] de;
    logic       alarm;
    logic       running;
    logic [1:0] sel_field;

    int n_chk = 0;
    int n_fail = 0;

    countdown_timer #(
        .TICK_DIV     (1000),
        .DEB_LEN      (7),
        .ALARM_CYCLES (3000)
    ) dut (
        .kclk      (kclk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_sel   (btn_sel),
        .btn_inc   (btn_inc),
        .speed     (speed),
        .seg       (seg),
        .de        (de),
        .alarm     (alarm),
        .running   (running),
        .sel_field (sel_field)
    );

    always #5 kclk = ~kclk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'b1111110;
            1: s = 7'b0110000;
            2: s = 7'b1101101;
            3: s = 7'b1111001;
            4: s = 7'b0110011;
            5: s = 7'b1011011;
            6: s = 7'b1011111;
            7: s = 7'b1110000;
            8: s = 7'b1111111;
            9: s = 7'b1111011;
            default: s = 7'b0011111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] tm();
        return 32'(dut.tm_q);
    endfunction

    // Hold buttons long enough for one pulse; returns
    // at the negedge right after the DUT acted on it.
    task automatic press(input logic s, input logic l, input logic i);
        repeat (2) @(negedge kclk);
        btn_start = s;
        btn_sel   = l;
        btn_inc   = i;
        repeat (8) @(negedge kclk);
        btn_start = 1'b0;
        btn_sel   = 1'b0;
        btn_inc   = 1'b0;
    endtask

    task automatic taps(input int n, input logic l, input logic i);
        for (int k = 0; k < n; k++)
            press(1'b0, l, i);
    endtask

    initial begin
        int cnt;
        int d;
        int prev;
        int exp_dig[6];

        repeat (3) @(negedge kclk);
        chk("rst_tm", tm(), 32'h0);
        chk("rst_run", 32'(running), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_sel", 32'(sel_field), 32'd0);
        chk("rst_de", 32'(de), 32'd0);
        rst = 1'b0;

        taps(2, 1'b1, 1'b0);
        chk("sel_x2", 32'(sel_field), 32'd2);
        taps(61, 1'b0, 1'b1);
        chk("sec_inc61", tm(), 32'h000001);
        taps(1, 1'b1, 1'b0);
        chk("sel_wrap", 32'(sel_field), 32'd0);
        taps(13, 1'b0, 1'b1);
        chk("hr_inc13", tm(), 32'h010001);

        exp_dig = '{0, 1, 0, 0, 0, 1};
        @(negedge kclk);
        prev = int'(de);
        for (int k = 0; k < 6; k++) begin
            @(negedge kclk);
            d = int'(de);
            chk("scan_de", 32'(d), 32'((prev + 1) % 6));
            chk("scan_seg", 32'(seg), 32'(ref_seg(exp_dig[d])));
            prev = d;
        end

        @(negedge kclk);
        btn_inc = 1'b1;
        repeat (6) @(negedge kclk);
        btn_inc = 1'b0;
        repeat (10) @(negedge kclk);
        chk("glitch", tm(), 32'h010001);

        taps(2, 1'b1, 1'b0);
        taps(59, 1'b0, 1'b1);
        chk("preset_1h", tm(), 32'h010000);
        speed = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        chk("run_go", 32'(running), 32'd1);
        chk("run_hold", tm(), 32'h010000);
        @(negedge kclk);
        chk("borrow1", tm(), 32'h005959);
        @(negedge kclk);
        chk("borrow2", tm(), 32'h005958);

        rst = 1'b1;
        #1;
        chk("rst1_tm", tm(), 32'h0);
        chk("rst1_run", 32'(running), 32'd0);
        @(negedge kclk);
        rst = 1'b0;

        taps(2, 1'b1, 1'b0);
        taps(2, 1'b0, 1'b1);
        chk("preset_2s", tm(), 32'h000002);
        press(1'b1, 1'b0, 1'b0);
        chk("exp_run", 32'(running), 32'd1);
        @(negedge kclk);
        chk("exp_01", tm(), 32'h000001);
        @(negedge kclk);
        chk("exp_00", tm(), 32'h000000);
        chk("exp_00_alarm", 32'(alarm), 32'd0);
        @(negedge kclk);
        chk("alarm_on", 32'(alarm), 32'd1);
        chk("alarm_run", 32'(running), 32'd0);
        cnt = 0;
        while (alarm && cnt < 4000) begin
            cnt++;
            @(negedge kclk);
        end
        chk("alarm_len", 32'(cnt), 32'd3000);
        chk("alarm_off", 32'(alarm), 32'd0);
        chk("after_tm", tm(), 32'h0);
        chk("after_run", 32'(running), 32'd0);

        press(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge kclk);
        chk("zero_start", 32'(running), 32'd0);
        chk("zero_alarm", 32'(alarm), 32'd0);

        taps(30, 1'b0, 1'b1);
        chk("preset_30", tm(), 32'h000030);
        speed = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        chk("pause_run", 32'(running), 32'd1);
        press(1'b1, 1'b0, 1'b0);
        chk("paused", 32'(running), 32'd0);
        chk("paused_tm", tm(), 32'h000030);
        repeat (5000) @(negedge kclk);
        chk("frozen", tm(), 32'h000030);
        chk("frozen_run", 32'(running), 32'd0);
        press(1'b0, 1'b0, 1'b1);
        chk("pause_inc", tm(), 32'h000030);
        press(1'b1, 1'b0, 1'b0);
        chk("resume", 32'(running), 32'd1);
        chk("resume_tm", tm(), 32'h000030);
        repeat (1000) @(negedge kclk);
        chk("resume_tick", tm(), 32'h000029);

        rst = 1'b1;
        #1;
        chk("rst2_tm", tm(), 32'h0);
        @(negedge kclk);
        rst = 1'b0;

        taps(1, 1'b1, 1'b0);
        taps(5, 1'b0, 1'b1);
        chk("preset_5m", tm(), 32'h000500);
        press(1'b1, 1'b0, 1'b1);
        chk("prio_run", 32'(running), 32'd1);
        chk("prio_tm", tm(), 32'h000500);
        repeat (50) @(negedge kclk);
        chk("run_5m", tm(), 32'h000500);

        #2;
        rst = 1'b1;
        #1;
        chk("rst3_tm", tm(), 32'h0);
        chk("rst3_run", 32'(running), 32'd0);
        chk("rst3_alarm", 32'(alarm), 32'd0);
        chk("rst3_de", 32'(de), 32'd0);
        chk("rst3_sel", 32'(sel_field), 32'd0);
        @(negedge kclk);
        rst = 1'b0;
        chk("de_0", 32'(de), 32'd0);
        chk("seg_0", 32'(seg), 32'(ref_seg(0)));
        for (int k = 1; k <= 6; k++) begin
            @(negedge kclk);
            chk("de_seq", 32'(de), 32'(k % 6));
            chk("seg_zero", 32'(seg), 32'(ref_seg(0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
